traffic_light_fsm: RTL and testbench

TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

---
 rtl/traffic_light_fsm.sv | 147 ++++++++++++++
 tb/tb_traffic_light_fsm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_fsm.sv
// Two-way traffic light controller paced by a 1 Hz tick derived from clock1hz.
// Define TRAFFIC_PED_EN to add the pedestrian request latch and the WALK phase.
module traffic_light_fsm #(
    parameter int unsigned GREEN_TIME  = 20,
    parameter int unsigned YELLOW_TIME = 3,
    parameter int unsigned RED_TIME    = 1,
    parameter int unsigned PED_TIME    = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clock1hz,
    input  logic       ped_btn,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [5:0] countdown
);

`ifdef TRAFFIC_PED_EN
    typedef enum logic [2:0] {
        StNsGreen, StNsYellow, StAllRed1, StEwGreen, StEwYellow, StAllRed2, StWalk
    } state_e;
`else
    typedef enum logic [2:0] {
        StNsGreen, StNsYellow, StAllRed1, StEwGreen, StEwYellow, StAllRed2
    } state_e;
`endif

    localparam logic [5:0] GreenDur  = 6'(GREEN_TIME);
    localparam logic [5:0] YellowDur = 6'(YELLOW_TIME);
    localparam logic [5:0] RedDur    = 6'(RED_TIME);
`ifdef TRAFFIC_PED_EN
    localparam logic [5:0] PedDur    = 6'(PED_TIME);
`endif

    function automatic logic [5:0] dur(input state_e s);
        case (s)
            StNsGreen, StEwGreen:   return GreenDur;
            StNsYellow, StEwYellow: return YellowDur;
            StAllRed1, StAllRed2:   return RedDur;
`ifdef TRAFFIC_PED_EN
            StWalk:                 return PedDur;
`endif
            default:                return GreenDur;
        endcase
    endfunction

    state_e     state_q, state_d;
    logic [5:0] timer_q, timer_d;
    logic       c1_s1_q, c1_s2_q, c1_s3_q;
    logic       tick;

    // clock1hz is sampled as data; tick marks its synchronized rising edge.
    assign tick = c1_s2_q & ~c1_s3_q;

`ifdef TRAFFIC_PED_EN
    logic pb_s1_q, pb_s2_q;
    logic ped_req_q, ped_req_d;
`else
    logic unused_ped_btn;
    assign unused_ped_btn = ped_btn;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StNsGreen;
            timer_q   <= GreenDur;
            c1_s1_q   <= 1'b0;
            c1_s2_q   <= 1'b0;
            c1_s3_q   <= 1'b0;
`ifdef TRAFFIC_PED_EN
            pb_s1_q   <= 1'b0;
            pb_s2_q   <= 1'b0;
            ped_req_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            c1_s1_q   <= clock1hz;
            c1_s2_q   <= c1_s1_q;
            c1_s3_q   <= c1_s2_q;
`ifdef TRAFFIC_PED_EN
            pb_s1_q   <= ped_btn;
            pb_s2_q   <= pb_s1_q;
            ped_req_q <= ped_req_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
`ifdef TRAFFIC_PED_EN
        ped_req_d = ped_req_q;
        if (pb_s2_q && state_q != StWalk) ped_req_d = 1'b1;
`endif
        if (tick) begin
            if (timer_q > 6'd1) begin
                timer_d = timer_q - 6'd1;
            end else begin
                case (state_q)
                    StNsGreen:  state_d = StNsYellow;
                    StNsYellow: state_d = StAllRed1;
                    StAllRed1:  state_d = StEwGreen;
                    StEwGreen:  state_d = StEwYellow;
                    StEwYellow: state_d = StAllRed2;
                    StAllRed2: begin
`ifdef TRAFFIC_PED_EN
                        // Entering WALK consumes the request; this clear beats a same-cycle set.
                        if (ped_req_q) begin
                            state_d   = StWalk;
                            ped_req_d = 1'b0;
                        end else begin
                            state_d = StNsGreen;
                        end
`else
                        state_d = StNsGreen;
`endif
                    end
`ifdef TRAFFIC_PED_EN
                    StWalk:     state_d = StNsGreen;
`endif
                    default:    state_d = StNsGreen;
                endcase
                timer_d = dur(state_d);
            end
        end
    end

    always_comb begin
        ns_light  = 3'b100;
        ew_light  = 3'b100;
        walk      = 1'b0;
        countdown = timer_q;
        case (state_q)
            StNsGreen:  ns_light = 3'b001;
            StNsYellow: ns_light = 3'b010;
            StEwGreen:  ew_light = 3'b001;
            StEwYellow: ew_light = 3'b010;
`ifdef TRAFFIC_PED_EN
            StWalk:     walk = 1'b1;
`endif
            default:    ;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboard bench for traffic_light_fsm with G=5, Y=2, R=1, P=3.
// Stimulus pushes expected outputs and their edge; a monitor checks every output change.
module tb_traffic_light_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clock1hz = 1'b0;
    logic       ped_btn = 1'b0;
    logic [2:0] ns_light, ew_light;
    logic       walk;
    logic [5:0] countdown;

`ifdef TRAFFIC_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    traffic_light_fsm #(
        .GREEN_TIME (5),
        .YELLOW_TIME(2),
        .RED_TIME   (1),
        .PED_TIME   (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clock1hz (clock1hz),
        .ped_btn  (ped_btn),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk     (walk),
        .countdown(countdown)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Cycle positions: 0-4 NS green, 5-6 NS yellow, 7 all-red, 8-12 EW green,
    // 13-14 EW yellow, 15 all-red, 16-18 walk. State codes 0..6 in that order.
    localparam int CYC_ST [19] = '{0, 0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 3, 4, 4, 5, 6, 6, 6};
    localparam int CYC_CD [19] = '{5, 4, 3, 2, 1, 2, 1, 1, 5, 4, 3, 2, 1, 2, 1, 1, 3, 2, 1};

    typedef struct {
        logic [12:0] val;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   pos = 0;
    bit   mon_en = 1'b0;

    function automatic logic [12:0] exp_out(input int st, input int cd);
        logic [2:0] ns = 3'b100;
        logic [2:0] ew = 3'b100;
        logic       w = 1'b0;
        case (st)
            0: ns = 3'b001;
            1: ns = 3'b010;
            3: ew = 3'b001;
            4: ew = 3'b010;
            6: w = 1'b1;
            default: ;
        endcase
        return {ns, ew, w, 6'(cd)};
    endfunction

    function automatic int next_pos(input int p, input bit walk_exp);
        if (p == 15) return walk_exp ? 16 : 0;
        if (p == 18) return 0;
        return p + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int p, input int at_cyc);
        exp_t e;
        e.val = exp_out(CYC_ST[p], CYC_CD[p]);
        e.cyc = at_cyc;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        check($sformatf("%s ns_light", tag), ns_light, 3'b001);
        check($sformatf("%s ew_light", tag), ew_light, 3'b100);
        check($sformatf("%s walk", tag), walk, 1'b0);
        check($sformatf("%s countdown", tag), countdown, 6'd5);
    endtask

    // Rising edge on clock1hz right after posedge k; the effect is due at edge k+3.
    task automatic give_tick(input bit walk_exp, input int hold_hi);
        @(posedge clk);
        #1 clock1hz = 1'b1;
        pos = next_pos(pos, walk_exp);
        push_exp(pos, cyc + 3);
        repeat (hold_hi) @(posedge clk);
        #1 clock1hz = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 mon_en = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        pos = 0;
        check_reset_state("reset");
        @(negedge clk);
        #1 mon_en = 1'b1;
    endtask

    initial begin : monitor
        logic [12:0] cur;
        logic [12:0] last;
        exp_t        e;
        last = '0;
        forever begin
            @(negedge clk);
            cur = {ns_light, ew_light, walk, countdown};
            if (mon_en && cur !== last) begin
                check("lamp legality",
                      {31'b0, $onehot(ns_light) && $onehot(ew_light) &&
                              (ns_light == 3'b100 || ew_light == 3'b100)}, 1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected change: got 0x%0h, expected no change (cycle %0d)",
                             cur, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("outputs", cur, e.val);
                    check("tick latency edge", cyc, e.cyc);
                end
            end
            last = cur;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int k2;
        do_reset();

        // Plain cycle, no button.
        repeat (20) give_tick(1'b0, 4);

        // Button pulse during EW green.
        do_reset();
        repeat (8) give_tick(PED, 4);
        @(posedge clk);
        #1 ped_btn = 1'b1;
        repeat (4) @(posedge clk);
        #1 ped_btn = 1'b0;
        repeat (8) give_tick(PED, 4);
        while (pos != 0) give_tick(PED, 4);

        // Request was consumed: next cycle skips WALK.
        repeat (16) give_tick(1'b0, 4);

        // Button held through WALK and beyond; a fresh request follows WALK exit.
        ped_btn = 1'b1;
        repeat (16) give_tick(PED, 4);
        while (pos != 0) give_tick(PED, 4);
        ped_btn = 1'b0;
        repeat (16) give_tick(PED, 4);
        while (pos != 0) give_tick(PED, 4);

        // Reset on the same edge as the EW-yellow expiry tick; clock1hz left high.
        repeat (14) give_tick(1'b0, 4);
        @(posedge clk);
        #1 clock1hz = 1'b1;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        k2 = cyc;
        check_reset_state("reset on tick");
        @(negedge clk);
        #1 mon_en = 1'b1;
        pos = 1;
        push_exp(pos, k2 + 3);
        repeat (4) @(posedge clk);
        #1 clock1hz = 1'b0;
        repeat (4) @(posedge clk);

        // Static clock1hz, high then low, must not advance anything.
        give_tick(1'b0, 1000);
        repeat (1000) @(posedge clk);
        #1 check("static countdown", countdown, 6'd3);

        repeat (10) @(posedge clk);
        check("pending expectations", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
